// File: rtl/ones_counter_seq.sv
// ones_counter_seq: sequential population counter with valid/ready handshakes.
// Accepts a WIDTH-bit word and counts its set bits, CHUNK bits per clock.
// It then holds the count until the consumer accepts it.
// With WIDTH=15 it drops into datapaths built around the combinational OC15.
// Optional feature macro: ONES_COUNTER_THRESH_EN.
// When this macro is defined, the block adds a thresh input and an at_least output.
// at_least reports whether the count is >= the threshold sampled at accept.
module ones_counter_seq #(
    parameter int unsigned WIDTH = 15,
    parameter int unsigned CHUNK = 4,
    localparam int unsigned CW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_count,
    output logic             busy
`ifdef ONES_COUNTER_THRESH_EN
    ,
    input  logic [CW-1:0]    thresh,
    output logic             at_least
`endif
);

    // Number of COUNT cycles, and the padded shift-register width.
    localparam int unsigned STEPS = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int unsigned PW    = STEPS * CHUNK;
    localparam int unsigned SW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [SW-1:0] LAST_STEP = SW'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        HOLD
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [PW-1:0]   shreg;
    logic [CW-1:0]   acc;
    logic [SW-1:0]   step;
    logic [CW-1:0]   chunk_pop;
    logic [CW-1:0]   sum;
    logic            accept;
    logic            last_step;

`ifdef ONES_COUNTER_THRESH_EN
    logic [CW-1:0]   thresh_q;
`endif

    // State register; reset abandons any word in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs, decoded from the current state.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = COUNT;
                end
            end
            COUNT: begin
                busy = 1'b1;
                if (last_step) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign accept    = (state == IDLE) && in_valid;
    assign last_step = (state == COUNT) && (step == LAST_STEP);

    // Popcount of the chunk currently at the bottom of the shift register.
    always_comb begin
        chunk_pop = '0;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            chunk_pop = chunk_pop + CW'(shreg[i]);
        end
    end

    // The accumulator cannot overflow: the total never exceeds WIDTH.
    assign sum = acc + chunk_pop;

    // Datapath: load on accept, then shift/accumulate one chunk per cycle.
    // The word is zero-extended to PW, so a short final chunk only adds zeros.
    // out_count is only written on the last step and keeps its value afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg     <= '0;
            acc       <= '0;
            step      <= '0;
            out_count <= '0;
`ifdef ONES_COUNTER_THRESH_EN
            thresh_q  <= '0;
            at_least  <= 1'b0;
`endif
        end else if (accept) begin
            shreg     <= PW'(in_data);
            acc       <= '0;
            step      <= '0;
`ifdef ONES_COUNTER_THRESH_EN
            thresh_q  <= thresh;
`endif
        end else if (state == COUNT) begin
            shreg     <= shreg >> CHUNK;
            acc       <= sum;
            step      <= step + SW'(1);
            if (last_step) begin
                out_count <= sum;
`ifdef ONES_COUNTER_THRESH_EN
                at_least  <= (sum >= thresh_q);
`endif
            end
        end
    end

endmodule

// File: doc/ones_counter_seq.md
Name: ones_counter_seq

Overview:
- Parametrised sequential successor to the 15-input combinational ones-counter (OC15).
- Accepts a WIDTH-bit word over a valid/ready handshake and counts its set bits, CHUNK bits per clock.
- Returns the population count over a second valid/ready handshake.
- Trades latency for area; drops into the same datapaths as the combinational counter when WIDTH=15.

Parameters:
- WIDTH, 15: input word width in bits, >=1.
- CHUNK, 4: bits examined per COUNT cycle, 1..WIDTH.
- Derived: CW = $clog2(WIDTH+1) is the count width; STEPS = ceil(WIDTH/CHUNK) is the number of COUNT cycles.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a word.
- in_data  in  WIDTH  word to count.
- out_valid  out  1  out_count is valid.
- out_ready  in  1  consumer accepts the result.
- out_count  out  CW  number of ones in the accepted word.
- busy  out  1  high in COUNT or HOLD.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; shift register, accumulator and step counter cleared.
  - in_ready=1, out_valid=0, out_count=0, busy=0.
  - Takes effect immediately, including mid-COUNT or in HOLD; any in-flight word is discarded and no result is emitted.
- IDLE:
  - in_ready=1, busy=0.
  - On an edge with in_valid=1: latch in_data into the shift register, clear the accumulator, set step=0, go to COUNT.
  - in_valid=0 keeps the block in IDLE.
- COUNT:
  - in_ready=0, busy=1.
  - Each edge: add the popcount of the low CHUNK bits of the shift register to the accumulator; shift right by CHUNK; step++.
  - When WIDTH is not a multiple of CHUNK, the final chunk is zero-padded, so bits beyond WIDTH never contribute.
  - On the edge where step reaches STEPS-1: load the final sum into out_count and go to HOLD.
- HOLD:
  - out_valid=1, busy=1, in_ready=0; out_count stable.
  - On an edge with out_ready=1: go to IDLE, drop out_valid and raise in_ready the next cycle.
  - out_ready=0 holds indefinitely, with out_count unchanged.
- Latency:
  - out_valid rises exactly STEPS cycles after the input-accept edge.
  - Throughput is one word per STEPS+2 cycles with out_ready tied high.
- Arithmetic:
  - Accumulator is CW bits wide and cannot overflow (max value WIDTH).
  - out_count is zero-extended.
- in_data and in_valid are ignored outside IDLE; no input queueing.
- Edge cases:
  - CHUNK=WIDTH: STEPS=1, and out_valid rises one cycle after accept.
  - WIDTH=1: CW=1.
- out_count holds its last result after leaving HOLD until the next HOLD entry. Only out_valid qualifies it.

Optional Feature:
- Macro: ONES_COUNTER_THRESH_EN.
- When defined:
  - Adds input thresh [CW-1:0], sampled with in_data at accept.
  - Adds output at_least [1], registered alongside out_count.
  - at_least = (count >= thresh) and is valid with out_valid.
  - Resets to 0.
- When undefined: neither port exists and no compare logic is built.

Test Plan (WIDTH=15, CHUNK=4, STEPS=4 unless stated):
- Accept in_data=15'h7FFF -> out_valid rises 4 cycles after the accept edge, out_count=15; in_ready=0 throughout.
- Accept 15'h0000, then 15'h5555, with out_ready=1 -> out_count=0, then out_count=8; in_ready returns 1 cycle after each output handshake.
- Accept 15'h0F0F with out_ready=0 for 6 cycles after out_valid -> out_count=8 held stable and out_valid=1 throughout; a new in_valid offered meanwhile is not accepted.
- Accept 15'h7FFF, assert rst_n=0 at the 2nd COUNT cycle -> outputs go to reset values immediately; no out_valid follows. Accept 15'h0001 after release -> out_count=1.
- Exhaustive sweep of in_data 0..32767, back-to-back -> every out_count matches the reference popcount. Repeat with WIDTH=15, CHUNK=15 (latency 1) and WIDTH=7, CHUNK=3 (STEPS=3, padded last chunk).
- With ONES_COUNTER_THRESH_EN defined:
  - in_data=15'h00FF, thresh=8 -> at_least=1.
  - in_data=15'h00FF, thresh=9 -> at_least=0.
